// File: rtl/led_cycle_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_cycle_pkg
// Brief   : Shared widths, speed-level type and step-period helper for the
//           LED chaser.
// Revision: 1.0 - initial release
// ============================================================================
package led_cycle_pkg;

    localparam int LED_W      = 16;
    localparam int BTN_W      = 5;
    localparam int NUM_LEVELS = 5;

    typedef logic [2:0] speed_level_t;

    // Each level is four times faster than the previous one, floored at one cycle.
    function automatic int period_for_level(input int base, input speed_level_t level);
        int p;
        p = base >> (2 * level);
        return (p < 1) ? 1 : p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_cycler_if.sv
`default_nettype none
// ============================================================================
// Module  : led_cycler_if
// Brief   : Board-side signal bundle: push-button levels in, LED drive out.
// Revision: 1.0 - initial release
// ============================================================================
interface led_cycler_if;
    import led_cycle_pkg::*;

    logic [BTN_W-1:0] buttons;
    logic [LED_W-1:0] led;

    modport master (output buttons, input led);
    modport slave  (input buttons, output led);

endinterface
`default_nettype wire

// File: rtl/led_cycle_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : led_cycle_prescaler
// Brief   : Step-rate counter; emits a one-cycle tick every period_for_level()
//           cycles and restarts whenever the speed level changes.
// Revision: 1.0 - initial release
// ============================================================================
module led_cycle_prescaler
    import led_cycle_pkg::*;
#(
    parameter int BASE_DIV = 12_500_000
) (
    input  logic         clk,
    input  logic         rst,
    input  speed_level_t level,
    input  logic         level_changed,
    output logic         tick
);

    localparam int CNT_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last_count;

    always_comb begin
        last_count = CNT_W'(period_for_level(BASE_DIV, level) - 1);
    end

    // A level change suppresses the tick so the new rate starts from a clean count.
    assign tick = !level_changed && (cnt == last_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (level_changed || (cnt == last_count)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_cycler.sv
`default_nettype none
// ============================================================================
// Module  : led_cycler
// Brief   : Single-LED chaser with button-selected speed. Define
//           LED_CYCLE_BOUNCE_EN for ping-pong motion instead of wrap-around.
// Revision: 1.0 - initial release
// ============================================================================
module led_cycler
    import led_cycle_pkg::*;
#(
    parameter int BASE_DIV = 12_500_000,
    parameter int LED_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    led_cycler_if.slave  io
);

    logic [BTN_W-1:0] sync_meta;
    logic [BTN_W-1:0] sync_btn;
    speed_level_t     next_level;
    speed_level_t     level;
    logic             level_changed;
    logic             tick;
    logic [LED_W-1:0] led;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync_btn  <= '0;
        end else begin
            sync_meta <= io.buttons;
            sync_btn  <= sync_meta;
        end
    end

    // Highest pressed button wins; button 0 alone is the same as none.
    always_comb begin
        next_level = '0;
        casez (sync_btn)
            5'b1????: next_level = speed_level_t'(NUM_LEVELS - 1);
            5'b01???: next_level = 3'd3;
            5'b001??: next_level = 3'd2;
            5'b0001?: next_level = 3'd1;
            default:  next_level = 3'd0;
        endcase
    end

    assign level_changed = (next_level != level);

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else begin
            level <= next_level;
        end
    end

    led_cycle_prescaler #(
        .BASE_DIV      (BASE_DIV)
    ) u_prescaler (
        .clk           (clk),
        .rst           (rst),
        .level         (level),
        .level_changed (level_changed),
        .tick          (tick)
    );

`ifdef LED_CYCLE_BOUNCE_EN
    logic dir_right;

    // Direction flips on the step that leaves an end LED, so ends are never repeated.
    always_ff @(posedge clk) begin
        if (rst) begin
            led       <= LED_W'(1);
            dir_right <= 1'b0;
        end else if (tick) begin
            if (!dir_right) begin
                if (led[LED_W-1]) begin
                    dir_right <= 1'b1;
                    led       <= led >> 1;
                end else begin
                    led <= led << 1;
                end
            end else begin
                if (led[0]) begin
                    dir_right <= 1'b0;
                    led       <= led << 1;
                end else begin
                    led <= led >> 1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            led <= LED_W'(1);
        end else if (tick) begin
            led <= {led[LED_W-2:0], led[LED_W-1]};
        end
    end
`endif

    assign io.led = led;

endmodule
`default_nettype wire

// File: tb/tb_led_cycler.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_cycler
// Brief   : Directed self-checking bench for led_cycler with BASE_DIV=256.
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_cycler;

    localparam int BASE_DIV = 256;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    logic [15:0] exp_led;
    logic        exp_dir;

    led_cycler_if io ();

    led_cycler #(
        .BASE_DIV (BASE_DIV),
        .LED_W    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io       (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic advance_model();
`ifdef LED_CYCLE_BOUNCE_EN
        if (!exp_dir) begin
            if (exp_led == 16'h8000) begin
                exp_dir = 1'b1;
                exp_led = 16'h4000;
            end else begin
                exp_led = exp_led << 1;
            end
        end else begin
            if (exp_led == 16'h0001) begin
                exp_dir = 1'b0;
                exp_led = 16'h0002;
            end else begin
                exp_led = exp_led >> 1;
            end
        end
`else
        exp_led = (exp_led == 16'h8000) ? 16'h0001 : (exp_led << 1);
`endif
    endtask

    // Counts edges until led moves; inputs were last driven just after the previous edge.
    task automatic step(input string tag, input int exp_gap);
        int n;
        logic [15:0] prev;
        prev = io.led;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (io.led === prev && n < 2000);
        advance_model();
        check({tag, "_gap"}, n, exp_gap);
        check({tag, "_led"}, {16'h0, io.led}, {16'h0, exp_led});
    endtask

    initial begin
        int bad;
        int guard;
        vectors    = 0;
        errors     = 0;
        exp_led    = 16'h0001;
        exp_dir    = 1'b0;
        rst        = 1'b1;
        io.buttons = 5'b00000;

        // Reset and wrap at the slowest rate
        repeat (3) @(posedge clk);
        #1;
        check("reset_led", {16'h0, io.led}, 32'h0001);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) step("t1_step", 256);
        check("t1_top", {16'h0, io.led}, 32'h8000);
        step("t1_wrap", 256);

        // Speed sweep; each change is applied right after a step
        io.buttons = 5'b00001;
        step("t2_l0", 256);
        io.buttons = 5'b00010;
        step("t2_l1_lat", 3 + 64);
        step("t2_l1", 64);
        io.buttons = 5'b00100;
        step("t2_l2_lat", 3 + 16);
        step("t2_l2", 16);
        io.buttons = 5'b01000;
        step("t2_l3_lat", 3 + 4);
        step("t2_l3", 4);
        io.buttons = 5'b10000;
        step("t2_l4_lat", 3 + 1);
        step("t2_l4", 1);
        step("t2_l4b", 1);

        // Priority: old fast rate keeps stepping until the new level lands
        io.buttons = 5'b10011;
        step("t3_hi", 1);
        step("t3_hi2", 1);
        io.buttons = 5'b00011;
        step("t3_old_a", 1);
        step("t3_old_b", 1);
        step("t3_l1_lat", 1 + 64);
        step("t3_l1", 64);
        io.buttons = 5'b00000;
        step("t3_l0_lat", 3 + 256);
        step("t3_l0", 256);

        // Mid-operation reset
        io.buttons = 5'b01000;
        step("t4_lat", 7);
        guard = 0;
        while (exp_led != 16'h0010 && guard < 40) begin
            step("t4_run", 4);
            guard++;
        end
        check("t4_at_0010", {16'h0, io.led}, 32'h0010);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t4_rst_led", {16'h0, io.led}, 32'h0001);
        rst     = 1'b0;
        exp_led = 16'h0001;
        exp_dir = 1'b0;
        step("t4_after", 7);
        step("t4_next", 4);

        // Random button activity; exactly one LED must be lit every cycle
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) io.buttons = 5'($urandom_range(0, 31));
            @(posedge clk);
            #1;
            if ($countones(io.led) != 1) bad++;
        end
        check("t5_onehot_bad_cycles", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
